// File: rtl/wr_burst_sequencer.sv
// Round-robin write-channel sequencer: wr_valid for BURST_LEN cycles, then one do_wr commit
// MIN_GAP..MAX_GAP cycles later, or err when that window expires. Define WR_BURST_SEQ_ASSERT_EN for embedded SVA.
module wr_burst_sequencer #(
    parameter int NUM_REQ   = 2,
    parameter int BURST_LEN = 7,
    parameter int MIN_GAP   = 1,
    parameter int MAX_GAP   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    input  logic               commit_rdy,
    output logic               wr_valid,
    output logic               do_wr,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BW    = $clog2(BURST_LEN + 1);
    localparam int GW    = $clog2(MAX_GAP + 1);

    localparam logic [BW-1:0]    BURST_LAST = BW'(BURST_LEN);
    localparam logic [GW-1:0]    GAP_MIN    = GW'(MIN_GAP);
    localparam logic [GW-1:0]    GAP_MAX    = GW'(MAX_GAP);
    localparam logic [PTR_W:0]   REQ_CNT    = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [BW-1:0]      r_burst_cnt;
    logic [GW-1:0]      r_gap_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_done;
    logic               r_err;

    state_t             w_state_next;
    logic [NUM_REQ-1:0] w_gnt_next;
    logic [BW-1:0]      w_burst_next;
    logic [GW-1:0]      w_gap_next;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               w_done_next;
    logic               w_err_next;
    logic               w_do_wr;

    logic               w_win_vld;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W:0]     w_idx_ext;

    // Scan offsets from farthest to nearest so the nearest requester at/after the pointer wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_idx_ext = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx_ext = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_idx_ext >= REQ_CNT) begin
                w_idx_ext = w_idx_ext - REQ_CNT;
            end
            if (req[w_idx_ext]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_idx_ext[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_burst_next = r_burst_cnt;
        w_gap_next   = r_gap_cnt;
        w_ptr_next   = r_ptr;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_do_wr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_next = '0;
                if (w_win_vld) begin
                    w_gnt_next[w_win_idx] = 1'b1;
                    w_state_next          = ST_BURST;
                    w_burst_next          = BW'(1);
                    w_ptr_next            = (w_win_idx == PTR_LAST) ? '0 : w_win_idx + 1'b1;
                end
            end
            ST_BURST: begin
                if (r_burst_cnt == BURST_LAST) begin
                    w_state_next = ST_GAP;
                    w_burst_next = '0;
                    w_gap_next   = GW'(1);
                end else begin
                    w_burst_next = r_burst_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if ((r_gap_cnt >= GAP_MIN) && commit_rdy) begin
                    w_do_wr      = 1'b1;
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                    w_gnt_next   = '0;
                    w_gap_next   = '0;
                end else if (r_gap_cnt == GAP_MAX) begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b1;
                    w_gnt_next   = '0;
                    w_gap_next   = '0;
                end else begin
                    w_gap_next = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
                w_burst_next = '0;
                w_gap_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_ptr       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_gnt       <= w_gnt_next;
            r_burst_cnt <= w_burst_next;
            r_gap_cnt   <= w_gap_next;
            r_ptr       <= w_ptr_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
        end
    end

    assign gnt      = r_gnt;
    assign wr_valid = (r_state == ST_BURST);
    assign busy     = (r_state != ST_IDLE);
    assign do_wr    = w_do_wr;
    assign done     = r_done;
    assign err      = r_err;

`ifdef WR_BURST_SEQ_ASSERT_EN
    default clocking cb_main @(posedge clk);
    endclocking
    default disable iff (!rst_n);

    sequence s_burst;
        wr_valid [*BURST_LEN];
    endsequence

    // A transaction closes with either a commit or an err pulse one cycle after the window ends.
    sequence s_close;
        do_wr or (1'b1 ##1 err);
    endsequence

    property p_burst_shape;
        $rose(wr_valid) |-> s_burst ##1 !wr_valid;
    endproperty

    property p_commit_window;
        $rose(wr_valid) |-> s_burst ##[MIN_GAP:MAX_GAP] s_close;
    endproperty

    a_burst_shape:   assert property (p_burst_shape);
    a_commit_window: assert property (p_commit_window);
    a_gnt_onehot:    assert property ($onehot0(gnt));
    a_do_wr_pulse:   assert property (do_wr |=> !do_wr);
    a_done_err_excl: assert property (!(done && err));

    c_min_gap_commit: cover property (do_wr && (r_gap_cnt == GAP_MIN));
    c_max_gap_commit: cover property (do_wr && (r_gap_cnt == GAP_MAX));
    c_timeout:        cover property (err);
`endif

endmodule
